// File: rtl/delay_timer_pkg.sv
// Shared encodings for the delay timer and its tick selector.
//   unit_e  : delay time base carried with a request (clk / us / ms / s)
//   state_e : delay timer control states
package delay_timer_pkg;

  localparam int unsigned UNIT_W = 2;

  typedef enum logic [UNIT_W-1:0] {
    UNIT_CLK = 2'd0,
    UNIT_US  = 2'd1,
    UNIT_MS  = 2'd2,
    UNIT_S   = 2'd3
  } unit_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

endpackage

// File: rtl/delay_timer_tick_sel.sv
// Combinational 4:1 strobe mux: picks the count-enable strobe for a time base.
// Reusable by any consumer of the clock-divider tick chain.
//   unit_i    : time base (UNIT_CLK/US/MS/S)
//   tick_us_i : 1 us strobe
//   tick_ms_i : 1 ms strobe
//   tick_s_i  : 1 s strobe
//   sel_o     : selected strobe (constant 1 for UNIT_CLK)
module delay_timer_tick_sel
  import delay_timer_pkg::*;
(
  input  logic [UNIT_W-1:0] unit_i,
  input  logic              tick_us_i,
  input  logic              tick_ms_i,
  input  logic              tick_s_i,
  output logic              sel_o
);

  always_comb begin
    sel_o = 1'b0;
    case (unit_i)
      UNIT_CLK: sel_o = 1'b1;
      UNIT_US:  sel_o = tick_us_i;
      UNIT_MS:  sel_o = tick_ms_i;
      UNIT_S:   sel_o = tick_s_i;
    endcase
  end

endmodule

// File: rtl/delay_timer.sv
// Programmable delay service driven by the 1 us / 1 ms / 1 s tick strobes.
// A request (unit, count) is taken over valid/ready; done pulses once when
// the count has elapsed, aborted pulses once when a running delay is cancelled.
//   clk, rst        : clock, synchronous active-high reset
//   tick_us/ms/s    : single-cycle time-base strobes (same clock domain)
//   req_valid/ready : request handshake; req_unit, req_count are the payload
//   req_periodic    : auto-reload request (only with DELAY_TIMER_PERIODIC_EN)
//   abort           : cancel the running delay
//   busy, done, aborted, remaining : registered status
// Build option: define DELAY_TIMER_PERIODIC_EN to add periodic (auto-reload) mode.
module delay_timer
  import delay_timer_pkg::*;
#(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tick_us,
  input  logic             tick_ms,
  input  logic             tick_s,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [1:0]       req_unit,
  input  logic [CNT_W-1:0] req_count,
`ifdef DELAY_TIMER_PERIODIC_EN
  input  logic             req_periodic,
`endif
  input  logic             abort,
  output logic             busy,
  output logic             done,
  output logic             aborted,
  output logic [CNT_W-1:0] remaining
);

  state_e            state_q;
  logic [UNIT_W-1:0] unit_q;
  logic [CNT_W-1:0]  count_q;
  logic [CNT_W-1:0]  remaining_q;
  logic              periodic_q;
  logic              req_ready_q;
  logic              busy_q;
  logic              done_q;
  logic              aborted_q;

  logic              req_per;
  logic              sel;
  logic [CNT_W-1:0]  req_count_d;
  logic [CNT_W-1:0]  rem_dec_d;
  logic              last_d;

`ifdef DELAY_TIMER_PERIODIC_EN
  assign req_per = req_periodic;
`else
  assign req_per = 1'b0;
`endif

  // A periodic request of zero would never tick; it runs as a period of one.
  assign req_count_d = (req_per && (req_count == '0)) ? CNT_W'(1) : req_count;

  // Saturating decrement so remaining can never wrap.
  assign rem_dec_d = (remaining_q != '0) ? remaining_q - CNT_W'(1) : '0;
  assign last_d    = (remaining_q == CNT_W'(1));

  delay_timer_tick_sel u_tick_sel (
    .unit_i    (unit_q),
    .tick_us_i (tick_us),
    .tick_ms_i (tick_ms),
    .tick_s_i  (tick_s),
    .sel_o     (sel)
  );

  // Control FSM and down-counter; all status outputs registered.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      unit_q      <= '0;
      count_q     <= '0;
      remaining_q <= '0;
      periodic_q  <= 1'b0;
      req_ready_q <= 1'b1;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      aborted_q   <= 1'b0;
    end else begin
      done_q    <= 1'b0;
      aborted_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          // Ticks in the acceptance cycle are not looked at: counting starts next cycle.
          if (req_valid && req_ready_q) begin
            unit_q     <= req_unit;
            count_q    <= req_count_d;
            periodic_q <= req_per;
            if (req_count_d != '0) begin
              state_q     <= ST_RUN;
              remaining_q <= req_count_d;
              busy_q      <= 1'b1;
              req_ready_q <= 1'b0;
            end else begin
              done_q <= 1'b1;
            end
          end
        end
        ST_RUN: begin
          // Abort takes priority over a coincident final tick.
          if (abort) begin
            state_q     <= ST_IDLE;
            remaining_q <= '0;
            busy_q      <= 1'b0;
            req_ready_q <= 1'b1;
            aborted_q   <= 1'b1;
          end else if (sel) begin
            if (last_d) begin
              done_q <= 1'b1;
              if (periodic_q) begin
                remaining_q <= count_q;
              end else begin
                state_q     <= ST_IDLE;
                remaining_q <= '0;
                busy_q      <= 1'b0;
                req_ready_q <= 1'b1;
              end
            end else begin
              remaining_q <= rem_dec_d;
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign req_ready = req_ready_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign aborted   = aborted_q;
  assign remaining = remaining_q;

endmodule

// File: tb/tb_delay_timer.sv
// Self-checking bench for delay_timer: directed scenarios plus randomized traffic,
// compared every cycle against a behavioural reference of the delay service.
module tb_delay_timer;

  localparam int unsigned CNT_W = 16;
`ifdef DELAY_TIMER_PERIODIC_EN
  localparam bit PER_EN = 1'b1;
`else
  localparam bit PER_EN = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             tick_us = 1'b0;
  logic             tick_ms = 1'b0;
  logic             tick_s = 1'b0;
  logic             req_valid = 1'b0;
  logic             req_ready;
  logic [1:0]       req_unit = 2'd0;
  logic [CNT_W-1:0] req_count = '0;
  logic             req_periodic = 1'b0;
  logic             abort = 1'b0;
  logic             busy;
  logic             done;
  logic             aborted;
  logic [CNT_W-1:0] remaining;

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  int us_per = 12;
  int ms_per = 7;
  int s_per = 40;

  always #5 clk = ~clk;

  delay_timer #(.CNT_W(CNT_W)) dut (
    .clk          (clk),
    .rst          (rst),
    .tick_us      (tick_us),
    .tick_ms      (tick_ms),
    .tick_s       (tick_s),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_unit     (req_unit),
    .req_count    (req_count),
`ifdef DELAY_TIMER_PERIODIC_EN
    .req_periodic (req_periodic),
`endif
    .abort        (abort),
    .busy         (busy),
    .done         (done),
    .aborted      (aborted),
    .remaining    (remaining)
  );

  // Reference: a pending delay is just "units left" plus its time base.
  bit m_active = 1'b0;
  bit m_per = 1'b0;
  int m_unit = 0;
  int m_left = 0;
  int m_reload = 0;
  bit e_ready = 1'b1;
  bit e_busy = 1'b0;
  bit e_done = 1'b0;
  bit e_aborted = 1'b0;
  int e_rem = 0;

  always @(posedge clk) begin : model
    bit tk;
    int n;
    e_done = 1'b0;
    e_aborted = 1'b0;
    if (rst) begin
      m_active = 1'b0;
      m_left = 0;
      m_reload = 0;
      m_unit = 0;
      m_per = 1'b0;
    end else if (!m_active) begin
      if (req_valid) begin
        n = int'(req_count);
        if (PER_EN && req_periodic && n == 0) n = 1;
        if (n == 0) begin
          e_done = 1'b1;
        end else begin
          m_active = 1'b1;
          m_unit = int'(req_unit);
          m_left = n;
          m_reload = n;
          m_per = PER_EN && req_periodic;
        end
      end
    end else begin
      tk = (m_unit == 0) || (m_unit == 1 && tick_us) ||
           (m_unit == 2 && tick_ms) || (m_unit == 3 && tick_s);
      if (abort) begin
        m_active = 1'b0;
        m_left = 0;
        e_aborted = 1'b1;
      end else if (tk) begin
        m_left = m_left - 1;
        if (m_left == 0) begin
          e_done = 1'b1;
          if (m_per) m_left = m_reload;
          else m_active = 1'b0;
        end
      end
    end
    e_busy = m_active;
    e_ready = !m_active;
    e_rem = m_left;
  end

  task automatic chk(input string nm, input int act, input int exp_v);
    n_vec++;
    if (act != exp_v) begin
      n_err++;
      $display("FAIL %s cyc=%0d: got %0d want %0d", nm, cyc, act, exp_v);
    end
  endtask

  // One clock: compare against the reference just after the edge, then set up
  // the tick strobes for the coming cycle.
  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    chk("req_ready", int'(req_ready), int'(e_ready));
    chk("busy", int'(busy), int'(e_busy));
    chk("done", int'(done), int'(e_done));
    chk("aborted", int'(aborted), int'(e_aborted));
    chk("remaining", int'(remaining), e_rem);
    tick_us = (cyc % us_per) == 0;
    tick_ms = (cyc % ms_per) == 0;
    tick_s  = (cyc % s_per) == 0;
  endtask

  task automatic request(input int unit, input int count, input bit per);
    req_valid = 1'b1;
    req_unit = 2'(unit);
    req_count = CNT_W'(count);
    req_periodic = per;
  endtask

  initial begin : drive
    int seen;
    int n_done;
    int n_ab;
    int run_len;
    bit will_accept;
    int rem_exp[6];
    rem_exp = '{5, 4, 3, 2, 1, 0};

    // Reset values
    rst = 1'b1;
    step();
    step();
    chk("rst_ready", int'(req_ready), 1);
    chk("rst_busy", int'(busy), 0);
    chk("rst_rem", int'(remaining), 0);
    rst = 1'b0;
    step();

    // unit 0, count 5: busy for 5 cycles, done on the 6th only
    request(0, 5, 1'b0);
    step();
    req_valid = 1'b0;
    for (int i = 0; i < 6; i++) begin
      chk("t_clk_rem", int'(remaining), rem_exp[i]);
      chk("t_clk_done", int'(done), (i == 5) ? 1 : 0);
      chk("t_clk_busy", int'(busy), (i < 5) ? 1 : 0);
      step();
    end
    chk("t_clk_done_once", int'(done), 0);

    // count 0: immediate done, never busy
    request(2, 0, 1'b0);
    step();
    req_valid = 1'b0;
    chk("t_zero_done", int'(done), 1);
    chk("t_zero_busy", int'(busy), 0);
    chk("t_zero_ready", int'(req_ready), 1);
    step();
    chk("t_zero_done_once", int'(done), 0);

    // unit us, count 3 with tick_us every 12 cycles
    request(1, 3, 1'b0);
    step();
    req_valid = 1'b0;
    n_done = 0;
    n_ab = 0;
    for (int i = 0; i < 45; i++) begin
      step();
      if (done) n_done++;
      if (aborted) n_ab++;
    end
    chk("t_us_dones", n_done, 1);
    chk("t_us_aborts", n_ab, 0);

    // unit ms, count 4, abort after the 2nd tick_ms, then immediate new request
    request(2, 4, 1'b0);
    step();
    req_valid = 1'b0;
    seen = 0;
    for (int k = 0; k < 200 && seen < 2; k++) begin
      bit t;
      t = tick_ms;
      step();
      if (t) seen++;
    end
    chk("t_ms_rem_mid", int'(remaining), 2);
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk("t_ms_aborted", int'(aborted), 1);
    chk("t_ms_done", int'(done), 0);
    chk("t_ms_rem", int'(remaining), 0);
    request(0, 1, 1'b0);
    step();
    req_valid = 1'b0;
    chk("t_after_abort_busy", int'(busy), 1);
    step();
    chk("t_after_abort_done", int'(done), 1);

    // abort coinciding with the final tick
    request(0, 2, 1'b0);
    step();
    req_valid = 1'b0;
    step();
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk("t_race_aborted", int'(aborted), 1);
    chk("t_race_done", int'(done), 0);

    // reset mid-run
    request(0, 10, 1'b0);
    step();
    req_valid = 1'b0;
    step();
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("t_rst_busy", int'(busy), 0);
    chk("t_rst_ready", int'(req_ready), 1);
    chk("t_rst_rem", int'(remaining), 0);
    step();
    chk("t_rst_no_done", int'(done), 0);

`ifdef DELAY_TIMER_PERIODIC_EN
    // periodic, unit 0, count 3: done at T+4, T+7, T+10
    request(0, 3, 1'b1);
    step();
    req_valid = 1'b0;
    req_periodic = 1'b0;
    for (int k = 2; k <= 10; k++) begin
      step();
      chk("t_per_done", int'(done), (k >= 4 && (k % 3) == 1) ? 1 : 0);
      chk("t_per_busy", int'(busy), 1);
    end
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk("t_per_aborted", int'(aborted), 1);
    chk("t_per_idle", int'(busy), 0);
    step();
    chk("t_per_ready", int'(req_ready), 1);
`endif

    // Randomized traffic against the reference
    us_per = 3;
    ms_per = 5;
    s_per = 9;
    run_len = 0;
    for (int c = 0; c < 4000; c++) begin
      will_accept = req_valid && e_ready && !rst;
      step();
      if (will_accept) req_valid = 1'b0;
      run_len = e_busy ? run_len + 1 : 0;
      rst = ($urandom_range(0, 599) == 0);
      if (e_busy) abort = ($urandom_range(0, 29) == 0) || (run_len > 300);
      else abort = ($urandom_range(0, 49) == 0);
      if (!req_valid && $urandom_range(0, 3) == 0) begin
        int u;
        int n;
        u = int'($urandom_range(0, 3));
        if (u == 0 && $urandom_range(0, 19) == 0) n = 65535;
        else if (u <= 1) n = int'($urandom_range(0, 20));
        else n = int'($urandom_range(0, 6));
        request(u, n, $urandom_range(0, 3) == 0);
      end
    end
    req_valid = 1'b0;
    abort = 1'b0;
    rst = 1'b0;
    for (int i = 0; i < 5; i++) step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/delay_timer.md
Name: delay_timer

Overview:
- Consumer end of the tick-strobe chain: takes the 1 us / 1 ms / 1 s single-cycle strobes from the clock divider and services programmable delay requests.
- Requests arrive over a valid/ready handshake; completion is signalled with a one-cycle done pulse.
- Used by bare-metal peripherals (I2C init waits, LED blink, power-up sequencing) so each one needs no private counter.

Parameters:
- CNT_W, 16, width of the delay count and of the remaining-count output.

Ports:
- clk  in  1  system clock; same domain as the tick strobes
- rst  in  1  synchronous reset, active-high
- tick_us  in  1  1 us strobe, one cycle wide
- tick_ms  in  1  1 ms strobe, one cycle wide
- tick_s  in  1  1 s strobe, one cycle wide
- req_valid  in  1  delay request valid
- req_ready  out  1  block can accept a request
- req_unit  in  2  0=clk cycles, 1=us, 2=ms, 3=s
- req_count  in  CNT_W  number of units to wait
- abort  in  1  cancel the active delay
- busy  out  1  delay in progress
- done  out  1  one-cycle completion pulse
- aborted  out  1  one-cycle abort acknowledge
- remaining  out  CNT_W  units still to wait

Behaviour:
- Reset values (registered outputs): req_ready=1, busy=0, done=0, aborted=0, remaining=0. State goes to IDLE; latched unit and count are cleared.
- FSM states: IDLE, RUN.
- IDLE:
  - req_ready=1.
  - Accept when req_valid && req_ready in cycle T: latch unit and count.
  - count!=0: go to RUN; at T+1 busy=1, req_ready=0, remaining=count.
  - count==0: stay IDLE; done=1 at T+1, busy stays 0.
- RUN, tick selection: sel = 1 for unit 0, tick_us for unit 1, tick_ms for unit 2, tick_s for unit 3.
- RUN, on a sel cycle:
  - remaining decrements by 1.
  - If remaining==1, go to IDLE. At the next cycle: done=1, busy=0, req_ready=1, remaining=0.
- Tick strobes in the acceptance cycle T are ignored; counting starts at T+1.
- First-unit granularity: the first us/ms/s unit may be partial (up to one unit short). Unit 0 is exact: count N gives done at T+N+1.
- done is high for exactly one cycle. A new request may be accepted in that same done cycle.
- abort:
  - Effective only in RUN. Next cycle: IDLE, busy=0, aborted=1 for one cycle, remaining=0, no done.
  - abort in IDLE is ignored.
  - abort coinciding with the final tick: abort wins, no done.
- req_valid while busy is not accepted (req_ready=0). The requester must hold valid and payload until accepted.
- rst mid-delay: immediate return to reset values; no done, no aborted.
- remaining never wraps. Arithmetic is unsigned CNT_W bits; decrement only when remaining>=1.

Optional Feature:
- Macro: DELAY_TIMER_PERIODIC_EN.
- Defined:
  - Adds input req_periodic (1 bit), latched on acceptance.
  - If set, the final tick reloads remaining with the latched count and pulses done for one cycle.
  - busy stays 1 and req_ready stays 0 until abort or rst.
  - Periodic with count 0 is treated as count 1.
- Undefined: the port is absent and every request is one-shot.

Decomposition:
- Shared package delay_timer_pkg:
  - unit encodings UNIT_CLK=2'd0, UNIT_US=2'd1, UNIT_MS=2'd2, UNIT_S=2'd3
  - state encodings ST_IDLE, ST_RUN
- Sub-module tick_sel: combinational 4:1 strobe mux keyed by the latched unit. It is kept separate so other tick consumers can reuse it.
- Remaining logic is a single FSM plus down-counter in delay_timer.

Test Plan:
- unit=0, count=5 accepted at cycle 10 -> busy cycles 11..15, done=1 at cycle 16 only, remaining 5,4,3,2,1 then 0.
- unit=1, count=3, tick_us every 12 cycles -> done one cycle after the 3rd tick_us following acceptance; aborted stays 0.
- count=0, any unit -> done at T+1, busy never 1, req_ready stays 1.
- unit=2, count=4, abort asserted after the 2nd tick_ms -> aborted=1 next cycle, remaining=0, no done. Then a new request is accepted the following cycle.
- Final tick and abort in the same cycle -> aborted=1, done=0. Separately, rst asserted mid-RUN -> all outputs at reset values next cycle.
- With DELAY_TIMER_PERIODIC_EN, unit=0, count=3, periodic=1 -> done at T+4, T+7, T+10..., busy held at 1. After abort: aborted pulse, then idle.
